// File: rtl/acos_arg_divider_pkg.sv
// Shared constants for the acos argument path: operand width, saturation value
// and the divider FSM state encoding.
package acos_arg_divider_pkg;

   localparam int unsigned ACOS_W = 32;
   localparam logic [ACOS_W-1:0] ACOS_SAT_VAL = 32'hFFFF_FFFF;

   typedef logic [1:0] state_t;

   localparam state_t StIdle = 2'd0;
   localparam state_t StCalc = 2'd1;
   localparam state_t StDone = 2'd2;

endpackage

// File: rtl/acos_arg_divider_div_step.sv
// One restoring-division step: shift the remainder left by one and subtract the
// denominator when it fits, producing the next quotient bit.
module acos_arg_divider_div_step #(
   parameter int unsigned IN_W = 32
) (
   input  logic [IN_W:0]   rem_in,
   input  logic [IN_W-1:0] den_in,
   output logic [IN_W:0]   rem_out,
   output logic            q_bit_out
);

   logic [IN_W:0] rem_shl;
   logic [IN_W:0] den_ext;

   assign rem_shl = {rem_in[IN_W-1:0], 1'b0};
   assign den_ext = {1'b0, den_in};

   // A set top bit means the true shifted value exceeds any denominator.
   assign q_bit_out = rem_in[IN_W] | (rem_shl >= den_ext);
   assign rem_out   = q_bit_out ? (rem_shl - den_ext) : rem_shl;

endmodule

// File: rtl/acos_arg_divider.sv
// Sequential restoring divider producing the acos argument q = floor(num * 2^OUT_W / den),
// with fixed latency regardless of saturation or divide-by-zero.
module acos_arg_divider
   import acos_arg_divider_pkg::*;
#(
   parameter int unsigned      IN_W    = ACOS_W,
   parameter int unsigned      OUT_W   = ACOS_W,
   parameter logic [OUT_W-1:0] SAT_VAL = ACOS_SAT_VAL
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [IN_W-1:0]  num_in,
   input  logic [IN_W-1:0]  den_in,
   input  logic             valid_in,
   output logic             busy_out,
   output logic [OUT_W-1:0] quot_out,
   output logic             valid_out,
   output logic             sat_out,
   output logic             div0_out
);

   localparam int unsigned CNT_W = $clog2(OUT_W + 1);

   state_t           state_q, state_d;
   logic [IN_W-1:0]  den_q, den_d;
   logic [IN_W:0]    rem_q, rem_d;
   logic [OUT_W-1:0] q_q, q_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_pend_q, sat_pend_d;
   logic             div0_pend_q, div0_pend_d;
   logic [OUT_W-1:0] quot_q, quot_d;
   logic             valid_q, valid_d;
   logic             sat_q, sat_d;
   logic             div0_q, div0_d;

   logic [IN_W:0] rem_step;
   logic          q_bit;

   acos_arg_divider_div_step #(
      .IN_W (IN_W)
   ) u_div_step (
      .rem_in    (rem_q),
      .den_in    (den_q),
      .rem_out   (rem_step),
      .q_bit_out (q_bit)
   );

   always_comb begin
      state_d     = state_q;
      den_d       = den_q;
      rem_d       = rem_q;
      q_d         = q_q;
      cnt_d       = cnt_q;
      sat_pend_d  = sat_pend_q;
      div0_pend_d = div0_pend_q;
      quot_d      = quot_q;
      valid_d     = 1'b0;
      sat_d       = sat_q;
      div0_d      = div0_q;

      case (state_q)
         StIdle: begin
            if (valid_in) begin
               den_d       = den_in;
               rem_d       = {1'b0, num_in};
               q_d         = '0;
               cnt_d       = '0;
               div0_pend_d = (den_in == '0);
               sat_pend_d  = (den_in != '0) && (num_in >= den_in);
               state_d     = StCalc;
            end
         end
         StCalc: begin
            // The iteration runs even for sat/div0 so latency never depends on operands.
            if (cnt_q == CNT_W'(OUT_W)) begin
               quot_d  = (sat_pend_q | div0_pend_q) ? SAT_VAL : q_q;
               sat_d   = sat_pend_q;
               div0_d  = div0_pend_q;
               valid_d = 1'b1;
               state_d = StDone;
            end else begin
               rem_d = rem_step;
               q_d   = {q_q[OUT_W-2:0], q_bit};
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q     <= StIdle;
         den_q       <= '0;
         rem_q       <= '0;
         q_q         <= '0;
         cnt_q       <= '0;
         sat_pend_q  <= 1'b0;
         div0_pend_q <= 1'b0;
         quot_q      <= '0;
         valid_q     <= 1'b0;
         sat_q       <= 1'b0;
         div0_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         den_q       <= den_d;
         rem_q       <= rem_d;
         q_q         <= q_d;
         cnt_q       <= cnt_d;
         sat_pend_q  <= sat_pend_d;
         div0_pend_q <= div0_pend_d;
         quot_q      <= quot_d;
         valid_q     <= valid_d;
         sat_q       <= sat_d;
         div0_q      <= div0_d;
      end
   end

   assign busy_out  = (state_q != StIdle);
   assign quot_out  = quot_q;
   assign valid_out = valid_q;
   assign sat_out   = sat_q;
   assign div0_out  = div0_q;

endmodule

// File: tb/tb_acos_arg_divider.sv
// Directed-vector and random bench for acos_arg_divider: latency, saturation,
// divide-by-zero, dropped requests while busy and synchronous reset abort.
module tb_acos_arg_divider;

   logic        clk_in;
   logic        rst_in;
   logic [31:0] num_in;
   logic [31:0] den_in;
   logic        valid_in;
   logic        busy_out;
   logic [31:0] quot_out;
   logic        valid_out;
   logic        sat_out;
   logic        div0_out;

   int n_checks = 0;
   int n_fail   = 0;
   int vo_count = 0;

   acos_arg_divider dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .num_in    (num_in),
      .den_in    (den_in),
      .valid_in  (valid_in),
      .busy_out  (busy_out),
      .quot_out  (quot_out),
      .valid_out (valid_out),
      .sat_out   (sat_out),
      .div0_out  (div0_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   always @(negedge clk_in) if (valid_out) vo_count++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [31:0] num;
      logic [31:0] den;
      logic [31:0] q;
      logic        sat;
      logic        div0;
      string       name;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Caller must be at a negedge; the request is sampled at the next posedge (edge 0).
   task automatic run_req(input logic [31:0] n, input logic [31:0] d, input logic [31:0] eq,
                          input logic es, input logic ed, input string name);
      int cyc;
      bit seen;
      num_in   = n;
      den_in   = d;
      valid_in = 1'b1;
      @(posedge clk_in);
      #1 valid_in = 1'b0;
      seen = 0;
      cyc  = 0;
      while (!seen && cyc < 40) begin
         @(posedge clk_in);
         cyc++;
         @(negedge clk_in);
         if (valid_out) seen = 1;
      end
      check({name, " latency"}, 64'(cyc), 64'd33);
      check({name, " quot"}, 64'(quot_out), 64'(eq));
      check({name, " sat"}, 64'(sat_out), 64'(es));
      check({name, " div0"}, 64'(div0_out), 64'(ed));
      @(posedge clk_in);
      @(negedge clk_in);
      check({name, " pulse width"}, 64'(valid_out), 64'd0);
      check({name, " busy clear"}, 64'(busy_out), 64'd0);
   endtask

   initial begin
      int   base;
      bit   busy_ok;
      logic [31:0] rn, rd;
      logic [63:0] dividend, rq;

      vecs[0] = '{32'd1, 32'd2, 32'h8000_0000, 1'b0, 1'b0, "1/2"};
      vecs[1] = '{32'd1, 32'd3, 32'h5555_5555, 1'b0, 1'b0, "1/3"};
      vecs[2] = '{32'd3, 32'd4, 32'hC000_0000, 1'b0, 1'b0, "3/4"};
      vecs[3] = '{32'd0, 32'd7, 32'h0000_0000, 1'b0, 1'b0, "0/7"};
      vecs[4] = '{32'd5, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0, "5/5 sat"};
      vecs[5] = '{32'd9, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, "9/0 div0"};
      vecs[6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, "0/0 div0"};
      vecs[7] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, "max-1/max"};
      vecs[8] = '{32'd1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "1/max"};
      vecs[9] = '{32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 1'b1, 1'b0, "max/3 sat"};

      rst_in   = 1'b1;
      valid_in = 1'b0;
      num_in   = '0;
      den_in   = '0;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b0;

      check("reset busy", 64'(busy_out), 64'd0);
      check("reset valid", 64'(valid_out), 64'd0);
      check("reset quot", 64'(quot_out), 64'd0);
      check("reset sat", 64'(sat_out), 64'd0);
      check("reset div0", 64'(div0_out), 64'd0);

      for (int i = 0; i < 10; i++)
         run_req(vecs[i].num, vecs[i].den, vecs[i].q, vecs[i].sat, vecs[i].div0, vecs[i].name);

      // Requests during CALC and during the valid_out cycle must be dropped.
      base     = vo_count;
      busy_ok  = 1;
      num_in   = 32'd1;
      den_in   = 32'd2;
      valid_in = 1'b1;
      @(posedge clk_in);
      #1 valid_in = 1'b0;
      for (int e = 1; e <= 33; e++) begin
         if (e == 5 || e == 33) begin
            num_in   = 32'd1;
            den_in   = 32'd4;
            valid_in = 1'b1;
         end
         @(posedge clk_in);
         #1 valid_in = 1'b0;
         @(negedge clk_in);
         if (!busy_out) busy_ok = 0;
      end
      check("drop busy held", 64'(busy_ok), 64'd1);
      check("drop valid", 64'(valid_out), 64'd1);
      check("drop quot", 64'(quot_out), 64'h8000_0000);
      num_in   = 32'd1;
      den_in   = 32'd4;
      valid_in = 1'b1;
      @(posedge clk_in);
      #1 valid_in = 1'b0;
      @(negedge clk_in);
      check("drop in done busy", 64'(busy_out), 64'd0);
      check("drop in done valid", 64'(valid_out), 64'd0);
      run_req(32'd1, 32'd4, 32'h4000_0000, 1'b0, 1'b0, "first idle 1/4");
      check("drop pulse count", 64'(vo_count - base), 64'd2);

      // Reset at edge 10 of a divide aborts it without a result.
      num_in   = 32'd1;
      den_in   = 32'd3;
      valid_in = 1'b1;
      @(posedge clk_in);
      #1 valid_in = 1'b0;
      repeat (9) @(posedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b0;
      check("abort busy", 64'(busy_out), 64'd0);
      check("abort quot", 64'(quot_out), 64'd0);
      check("abort valid", 64'(valid_out), 64'd0);
      base = vo_count;
      repeat (45) @(negedge clk_in);
      check("abort no pulse", 64'(vo_count - base), 64'd0);

      base = vo_count;
      for (int i = 0; i < 1000; i++) begin
         if (i % 2 == 0) rd = $urandom;
         else rd = 32'($urandom_range(1, 1000));
         if (rd == 32'd0) rd = 32'd1;
         rn       = $urandom % rd;
         dividend = {rn, 32'h0};
         rq       = dividend / {32'h0, rd};
         run_req(rn, rd, rq[31:0], 1'b0, 1'b0, "random");
      end
      check("random pulse count", 64'(vo_count - base), 64'd1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
